// File: rtl/mdu_iterative.sv
// Iterative radix-2 multiply/divide unit holding architectural HI/LO.
// Define MDU_EARLY_OUT_EN to finish multiplies once the remaining multiplier bits are zero.
module mdu_iterative #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      DW   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t           state;
    logic [DW-1:0]    acc;
    logic [WIDTH-1:0] opb;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             sgn_a;
    logic             sgn_b;
`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] mrem;
    logic [WIDTH-1:0] mrem_next;
`endif

    logic             sgn_a_in;
    logic             sgn_b_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next;
    logic [WIDTH+1:0] div_trial;
    logic [DW-1:0]    div_next;
    logic [DW-1:0]    acc_step;
    logic             step_last;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Operand magnitudes: signed ops (op[0]=0) take |x|, unsigned ops pass raw.
    always_comb begin
        sgn_a_in = ~op[0] & srca[WIDTH-1];
        sgn_b_in = ~op[0] & srcb[WIDTH-1];
        mag_a    = sgn_a_in ? (~srca + WIDTH'(1)) : srca;
        mag_b    = sgn_b_in ? (~srcb + WIDTH'(1)) : srcb;
    end

    // One iteration of shift-add multiply or restoring divide, plus the sign fixup.
    always_comb begin
        mul_sum   = {1'b0, acc[DW-1:WIDTH]} + {1'b0, (acc[0] ? opb : WIDTH'(0))};
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // The shifted partial remainder needs WIDTH+1 bits when the divisor exceeds 2^(WIDTH-1).
        div_trial = {1'b0, acc[DW-1:WIDTH-1]} - {2'b00, opb};
        div_next  = div_trial[WIDTH+1] ? {acc[DW-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        acc_step  = is_div ? div_next : mul_next;
        step_last = (cnt == LAST);
`ifdef MDU_EARLY_OUT_EN
        mrem_next = mrem >> 1;
        if (!is_div && (mrem_next == '0)) begin
            acc_step  = mul_next >> (LAST - cnt);
            step_last = 1'b1;
        end
`endif
        prod = (sgn_a ^ sgn_b) ? (~acc + DW'(1)) : acc;
        quot = acc[WIDTH-1:0];
        rem  = acc[DW-1:WIDTH];
        if (is_div) begin
            // Divide by zero leaves quot all-ones and rem=|dividend|; re-signing rem restores the raw dividend.
            res_lo = (opb == '0) ? '1 : ((sgn_a ^ sgn_b) ? (~quot + WIDTH'(1)) : quot);
            res_hi = sgn_a ? (~rem + WIDTH'(1)) : rem;
        end else begin
            res_hi = prod[DW-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    // Control FSM, working register and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
            mrem   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        is_div <= op[1];
                        sgn_a  <= sgn_a_in;
                        sgn_b  <= sgn_b_in;
                        opb    <= op[1] ? mag_b : mag_a;
                        acc    <= {WIDTH'(0), (op[1] ? mag_a : mag_b)};
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= CALC;
`ifdef MDU_EARLY_OUT_EN
                        mrem   <= mag_b;
                        if (!op[1] && (mag_b == '0)) state <= FIXUP;
`endif
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
`ifdef MDU_EARLY_OUT_EN
                    mrem <= mrem_next;
`endif
                    if (step_last) state <= FIXUP;
                end
                FIXUP: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
